// File: rtl/serial_add_ctrl.sv
// Bit-serial-by-slice adder controller: one shared carry-skip slice adder
// walks the operands BLOCK_SIZE bits per cycle, with valid/ready on both sides.

module CarrySkipModule #(
  parameter int OPERAND_SIZE = 16,
  parameter int BLOCK_SIZE   = 4
) (
  input  logic [OPERAND_SIZE-1:0] a,
  input  logic [OPERAND_SIZE-1:0] b,
  input  logic                    cin,
  output logic [OPERAND_SIZE-1:0] sum,
  output logic                    cout
);
  localparam int NUM_BLOCKS = OPERAND_SIZE / BLOCK_SIZE;

  // Each block ripples internally; when every bit propagates, the block
  // carry-in bypasses the ripple chain straight to the block carry-out.
  always_comb begin
    logic carry, blk_cin, ripple, prop, prop_all;
    // NOTE: combinational logic uses blocking '=' and gives every variable a
    // default first, so no latch can be inferred.
    sum      = '0;
    carry    = cin;
    blk_cin  = 1'b0;
    ripple   = 1'b0;
    prop     = 1'b0;
    prop_all = 1'b0;
    for (int blk = 0; blk < NUM_BLOCKS; blk++) begin
      blk_cin  = carry;
      ripple   = carry;
      prop_all = 1'b1;
      for (int i = 0; i < BLOCK_SIZE; i++) begin
        prop                       = a[blk*BLOCK_SIZE+i] ^ b[blk*BLOCK_SIZE+i];
        sum[blk*BLOCK_SIZE+i]      = prop ^ ripple;
        ripple                     = (a[blk*BLOCK_SIZE+i] & b[blk*BLOCK_SIZE+i]) | (prop & ripple);
        prop_all                   = prop_all & prop;
      end
      carry = prop_all ? blk_cin : ripple;
    end
    cout = carry;
  end
endmodule

module serial_add_ctrl #(
  parameter int OPERAND_SIZE = 64,
  parameter int BLOCK_SIZE   = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [OPERAND_SIZE-1:0] a,
  input  logic [OPERAND_SIZE-1:0] b,
  input  logic                    cin,
  input  logic                    sub,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [OPERAND_SIZE-1:0] sum,
  output logic                    cout,
  output logic                    ovf,
  output logic                    busy
);
  // BLOCK_SIZE must divide OPERAND_SIZE.
  localparam int N     = OPERAND_SIZE / BLOCK_SIZE;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);
  localparam int MSB   = OPERAND_SIZE - 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                  state_q, state_d;
  logic [OPERAND_SIZE-1:0] a_reg, b_reg, sum_reg;
  logic                    carry_reg, cout_reg, ovf_reg;
  logic [IDX_W-1:0]        idx;
  logic [BLOCK_SIZE-1:0]   a_slice, b_slice, add_sum;
  logic                    add_cout;
  logic                    accept, last_slice;

  assign accept     = in_valid && in_ready;
  assign last_slice = (idx == LAST_IDX);

  always_comb begin
    a_slice = '0;
    b_slice = '0;
    for (int s = 0; s < N; s++) begin
      if (idx == IDX_W'(s)) begin
        a_slice = a_reg[s*BLOCK_SIZE +: BLOCK_SIZE];
        b_slice = b_reg[s*BLOCK_SIZE +: BLOCK_SIZE];
      end
    end
  end

  CarrySkipModule #(
    .OPERAND_SIZE(BLOCK_SIZE),
    .BLOCK_SIZE  (4)
  ) u_slice_adder (
    .a   (a_slice),
    .b   (b_slice),
    .cin (carry_reg),
    .sum (add_sum),
    .cout(add_cout)
  );

  // NOTE: sequential state uses non-blocking '<=' so every register samples
  // pre-edge values and updates together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) state_d = RUN;
      end
      RUN:  if (last_slice) state_d = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: operand registers are cleared on reset as well; it costs little and
  // keeps an aborted operation from leaving anything observable behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg     <= '0;
      b_reg     <= '0;
      carry_reg <= 1'b0;
      idx       <= '0;
      sum_reg   <= '0;
      cout_reg  <= 1'b0;
      ovf_reg   <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: if (accept) begin
          a_reg     <= a;
          b_reg     <= sub ? ~b : b;
          carry_reg <= cin ^ sub;
          idx       <= '0;
        end
        RUN: begin
          for (int s = 0; s < N; s++) begin
            if (idx == IDX_W'(s)) sum_reg[s*BLOCK_SIZE +: BLOCK_SIZE] <= add_sum;
          end
          carry_reg <= add_cout;
          idx       <= last_slice ? '0 : idx + 1'b1;
          if (last_slice) begin
            cout_reg <= add_cout;
            ovf_reg  <= (a_reg[MSB] == b_reg[MSB]) && (add_sum[BLOCK_SIZE-1] != a_reg[MSB]);
          end
        end
        default: ;
      endcase
    end
  end

  assign sum  = sum_reg;
  assign cout = cout_reg;
  assign ovf  = ovf_reg;
endmodule
